// File: rtl/issue_queue_pkg.sv
// Issue queue shared types: entry layout and sequence-number age compare.
// Imported by the interface, the select tree and the queue top.
package issue_queue_pkg;

  localparam int SQN_W = 7;
  localparam int TAG_W = 7;
  localparam int PAYLOAD_W = 64;

  typedef logic [SQN_W-1:0] sqn_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic                 valid;
    sqn_t                 sqN;
    tag_t                 tagA;
    logic                 availA;
    tag_t                 tagB;
    logic                 availB;
    logic [PAYLOAD_W-1:0] payload;
  } iq_entry_t;

  // a older than b: signed wrap difference is negative
  function automatic logic sqn_older(
    input sqn_t a,
    input sqn_t b
  );
    sqn_t d;
    d = a - b;
    return d[SQN_W-1] && (d != '0);
  endfunction

  // a younger than b: signed wrap difference is positive
  function automatic logic sqn_younger(
    input sqn_t a,
    input sqn_t b
  );
    sqn_t d;
    d = a - b;
    return !d[SQN_W-1] && (d != '0);
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Issue queue bus: enqueue lanes, writeback broadcast, flush, issue port.
// master drives uops in, slave is the queue itself.
interface issue_queue_if #(
  parameter int WIDTH_UOPS = 4,
  parameter int WIDTH_WR   = 4,
  parameter int DEPTH      = 8
);
  import issue_queue_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH_UOPS-1:0]           IN_enqValid;
  logic [WIDTH_UOPS*SQN_W-1:0]     IN_enqSqN;
  logic [WIDTH_UOPS*TAG_W-1:0]     IN_enqTagA;
  logic [WIDTH_UOPS*TAG_W-1:0]     IN_enqTagB;
  logic [WIDTH_UOPS-1:0]           IN_enqAvailA;
  logic [WIDTH_UOPS-1:0]           IN_enqAvailB;
  logic [WIDTH_UOPS*PAYLOAD_W-1:0] IN_enqPayload;
  logic                            OUT_full;

  logic [WIDTH_WR-1:0]       IN_wbValid;
  logic [WIDTH_WR*TAG_W-1:0] IN_wbTag;

  logic IN_branchTaken;
  sqn_t IN_branchSqN;

  logic                 IN_issueStall;
  logic                 OUT_issueValid;
  sqn_t                 OUT_issueSqN;
  tag_t                 OUT_issueTagA;
  tag_t                 OUT_issueTagB;
  logic [PAYLOAD_W-1:0] OUT_issuePayload;
  logic [CNT_W-1:0]     OUT_freeCount;

  modport master (
    output IN_enqValid, IN_enqSqN,
    output IN_enqTagA, IN_enqTagB,
    output IN_enqAvailA, IN_enqAvailB,
    output IN_enqPayload,
    output IN_wbValid, IN_wbTag,
    output IN_branchTaken, IN_branchSqN,
    output IN_issueStall,
    input  OUT_full, OUT_freeCount,
    input  OUT_issueValid, OUT_issueSqN,
    input  OUT_issueTagA, OUT_issueTagB,
    input  OUT_issuePayload
  );

  modport slave (
    input  IN_enqValid, IN_enqSqN,
    input  IN_enqTagA, IN_enqTagB,
    input  IN_enqAvailA, IN_enqAvailB,
    input  IN_enqPayload,
    input  IN_wbValid, IN_wbTag,
    input  IN_branchTaken, IN_branchSqN,
    input  IN_issueStall,
    output OUT_full, OUT_freeCount,
    output OUT_issueValid, OUT_issueSqN,
    output OUT_issueTagA, OUT_issueTagB,
    output OUT_issuePayload
  );

endinterface

// File: rtl/issue_queue_select.sv
// Oldest-ready picker: pairwise age compare over all ready entries.
// sqNs are unique, so at most one grant bit is set.
module issue_select
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]       ready,
  input  logic [DEPTH*SQN_W-1:0] sqnVec,
  output logic [DEPTH-1:0]       grant,
  output logic                   found
);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && ready[j] &&
            sqn_older(sqnVec[j*SQN_W +: SQN_W],
                      sqnVec[i*SQN_W +: SQN_W]))
          grant[i] = 1'b0;
      end
    end
    found = |ready;
  end

endmodule

// File: rtl/issue_queue.sv
// Reservation station: tag wakeup, oldest-first issue, mispredict flush.
// Freed slots only become allocatable on the following cycle.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int WIDTH_UOPS = 4,
  parameter int WIDTH_WR   = 4,
  parameter int DEPTH      = 8
) (
  input logic         clk,
  input logic         rst,
  issue_queue_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  iq_entry_t q     [DEPTH];
  iq_entry_t qNext [DEPTH];

  logic [CNT_W-1:0] freeCount;
  logic [CNT_W-1:0] freeNext;
  logic             full;

  logic                 issueValid;
  sqn_t                 issueSqN;
  tag_t                 issueTagA;
  tag_t                 issueTagB;
  logic [PAYLOAD_W-1:0] issuePayload;

  logic [DEPTH-1:0]       ready;
  logic [DEPTH-1:0]       grant;
  logic                   found;
  logic [DEPTH*SQN_W-1:0] sqnVec;
  logic                   doIssue;

  sqn_t                 pickSqN;
  tag_t                 pickTagA;
  tag_t                 pickTagB;
  logic [PAYLOAD_W-1:0] pickPayload;

  logic [DEPTH-1:0] taken;
  logic             placed;

  function automatic logic wbHit(
    input logic [WIDTH_WR-1:0]       v,
    input logic [WIDTH_WR*TAG_W-1:0] tags,
    input tag_t                      t
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WIDTH_WR; k++)
      if (v[k] && tags[k*TAG_W +: TAG_W] == t)
        hit = 1'b1;
    return hit;
  endfunction

  assign full = freeCount < CNT_W'(WIDTH_UOPS);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = q[i].valid & q[i].availA
               & q[i].availB;
      sqnVec[i*SQN_W +: SQN_W] = q[i].sqN;
    end
  end

  issue_select #(
    .DEPTH(DEPTH)
  ) u_select (
    .ready (ready),
    .sqnVec(sqnVec),
    .grant (grant),
    .found (found)
  );

  assign doIssue = found & ~bus.IN_issueStall
                 & ~bus.IN_branchTaken;

  always_comb begin
    pickSqN     = '0;
    pickTagA    = '0;
    pickTagB    = '0;
    pickPayload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        pickSqN     = q[i].sqN;
        pickTagA    = q[i].tagA;
        pickTagB    = q[i].tagB;
        pickPayload = q[i].payload;
      end
    end
  end

  always_comb begin
    qNext  = q;
    taken  = '0;
    placed = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q[i].valid) begin
        qNext[i].availA = q[i].availA |
          wbHit(bus.IN_wbValid, bus.IN_wbTag,
                q[i].tagA);
        qNext[i].availB = q[i].availB |
          wbHit(bus.IN_wbValid, bus.IN_wbTag,
                q[i].tagB);
      end
    end
    if (bus.IN_branchTaken) begin
      for (int i = 0; i < DEPTH; i++)
        if (q[i].valid &&
            sqn_younger(q[i].sqN, bus.IN_branchSqN))
          qNext[i].valid = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (doIssue && grant[i])
          qNext[i].valid = 1'b0;
      // allocate from slots free at cycle start only
      for (int l = 0; l < WIDTH_UOPS; l++) begin
        placed = 1'b0;
        if (!full && bus.IN_enqValid[l]) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (!placed && !q[i].valid && !taken[i]) begin
              placed   = 1'b1;
              taken[i] = 1'b1;
              qNext[i].valid = 1'b1;
              qNext[i].sqN =
                bus.IN_enqSqN[l*SQN_W +: SQN_W];
              qNext[i].tagA =
                bus.IN_enqTagA[l*TAG_W +: TAG_W];
              qNext[i].tagB =
                bus.IN_enqTagB[l*TAG_W +: TAG_W];
              qNext[i].availA = bus.IN_enqAvailA[l] |
                wbHit(bus.IN_wbValid, bus.IN_wbTag,
                  bus.IN_enqTagA[l*TAG_W +: TAG_W]);
              qNext[i].availB = bus.IN_enqAvailB[l] |
                wbHit(bus.IN_wbValid, bus.IN_wbTag,
                  bus.IN_enqTagB[l*TAG_W +: TAG_W]);
              qNext[i].payload =
                bus.IN_enqPayload[l*PAYLOAD_W +: PAYLOAD_W];
            end
          end
        end
      end
    end
  end

  always_comb begin
    freeNext = '0;
    for (int i = 0; i < DEPTH; i++)
      if (!qNext[i].valid)
        freeNext = freeNext + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        q[i].valid <= 1'b0;
      freeCount  <= CNT_W'(DEPTH);
      issueValid <= 1'b0;
    end else begin
      q         <= qNext;
      freeCount <= freeNext;
      if (bus.IN_branchTaken) begin
        if (issueValid &&
            sqn_younger(issueSqN, bus.IN_branchSqN))
          issueValid <= 1'b0;
      end else if (!bus.IN_issueStall) begin
        issueValid <= found;
        if (found) begin
          issueSqN     <= pickSqN;
          issueTagA    <= pickTagA;
          issueTagB    <= pickTagB;
          issuePayload <= pickPayload;
        end
      end
    end
  end

  assign bus.OUT_full         = full;
  assign bus.OUT_freeCount    = freeCount;
  assign bus.OUT_issueValid   = issueValid;
  assign bus.OUT_issueSqN     = issueSqN;
  assign bus.OUT_issueTagA    = issueTagA;
  assign bus.OUT_issueTagB    = issueTagB;
  assign bus.OUT_issuePayload = issuePayload;

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: expected issue order queued at drive time.
// Cycle-exact checks cover wakeup latency, full, flush and reset.
module tb_issue_queue;
  import issue_queue_pkg::*;

  localparam int WU = 4;
  localparam int WW = 4;
  localparam int D  = 8;

  typedef struct {
    sqn_t                 sqN;
    logic [PAYLOAD_W-1:0] payload;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_queue_if #(
    .WIDTH_UOPS(WU), .WIDTH_WR(WW), .DEPTH(D)
  ) bus ();

  issue_queue #(
    .WIDTH_UOPS(WU), .WIDTH_WR(WW), .DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t sb[$];
  int   nVec = 0;
  int   nErr = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%0h exp=%0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pl(input int s);
    return 64'hFACE_0000_0000_0000 | (64'(s) << 8);
  endfunction

  task automatic clearIn();
    bus.IN_enqValid    = '0;
    bus.IN_enqSqN      = '0;
    bus.IN_enqTagA     = '0;
    bus.IN_enqTagB     = '0;
    bus.IN_enqAvailA   = '0;
    bus.IN_enqAvailB   = '0;
    bus.IN_enqPayload  = '0;
    bus.IN_wbValid     = '0;
    bus.IN_wbTag       = '0;
    bus.IN_branchTaken = 1'b0;
    bus.IN_branchSqN   = '0;
  endtask

  task automatic enq(
    input int lane, input int s,
    input int ta, input bit aa,
    input int tb, input bit ab
  );
    bus.IN_enqValid[lane]            = 1'b1;
    bus.IN_enqSqN[lane*7 +: 7]       = 7'(s);
    bus.IN_enqTagA[lane*7 +: 7]      = 7'(ta);
    bus.IN_enqTagB[lane*7 +: 7]      = 7'(tb);
    bus.IN_enqAvailA[lane]           = aa;
    bus.IN_enqAvailB[lane]           = ab;
    bus.IN_enqPayload[lane*64 +: 64] = pl(s);
  endtask

  task automatic wb(input int port, input int tag);
    bus.IN_wbValid[port]     = 1'b1;
    bus.IN_wbTag[port*7 +: 7] = 7'(tag);
  endtask

  task automatic flush(input int b);
    bus.IN_branchTaken = 1'b1;
    bus.IN_branchSqN   = 7'(b);
  endtask

  task automatic expectIssue(input int s);
    exp_t e;
    e.sqN     = 7'(s);
    e.payload = pl(s);
    sb.push_back(e);
  endtask

  // one clock edge; a fresh issue is scored against the queue head
  task automatic tick();
    logic stallE, brE, rstE;
    exp_t e;
    stallE = bus.IN_issueStall;
    brE    = bus.IN_branchTaken;
    rstE   = rst;
    @(posedge clk);
    #1;
    if (!rstE && !stallE && !brE &&
        bus.OUT_issueValid) begin
      check("sbHasEntry", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("issueSqN", 64'(bus.OUT_issueSqN),
              64'(e.sqN));
        check("issuePayload", bus.OUT_issuePayload,
              e.payload);
      end
    end
    clearIn();
  endtask

  initial begin
    clearIn();
    bus.IN_issueStall = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rstValid", 64'(bus.OUT_issueValid), 0);
    check("rstFree", 64'(bus.OUT_freeCount), 8);
    check("rstFull", 64'(bus.OUT_full), 0);

    // 1: single ready uop
    enq(0, 5, 1, 1, 2, 1);
    expectIssue(5);
    tick();
    check("t1Free7", 64'(bus.OUT_freeCount), 7);
    check("t1Early", 64'(bus.OUT_issueValid), 0);
    tick();
    check("t1Valid", 64'(bus.OUT_issueValid), 1);
    check("t1Free8", 64'(bus.OUT_freeCount), 8);
    tick();
    check("t1Idle", 64'(bus.OUT_issueValid), 0);

    // 2: wakeup by broadcast, 1-cycle wake-to-issue
    enq(0, 3, 12, 0, 13, 1);
    expectIssue(3);
    tick();
    check("t2e0", 64'(bus.OUT_issueValid), 0);
    tick();
    check("t2e1", 64'(bus.OUT_issueValid), 0);
    wb(0, 12);
    tick();
    check("t2e2", 64'(bus.OUT_issueValid), 0);
    tick();
    check("t2Issue", 64'(bus.OUT_issueValid), 1);
    check("t2TagA", 64'(bus.OUT_issueTagA), 12);
    check("t2TagB", 64'(bus.OUT_issueTagB), 13);

    // 3: age order, including sqN wrap
    enq(0, 9, 1, 1, 1, 1);
    enq(1, 7, 1, 1, 1, 1);
    expectIssue(7);
    expectIssue(9);
    tick();
    tick();
    tick();
    enq(0, 1, 1, 1, 1, 1);
    enq(1, 126, 1, 1, 1, 1);
    expectIssue(126);
    expectIssue(1);
    tick();
    tick();
    tick();
    tick();
    check("t3Idle", 64'(bus.OUT_issueValid), 0);

    // 4: full threshold blocks enqueue
    for (int l = 0; l < 4; l++)
      enq(l, 20 + l, 100, 0, 101, 1);
    tick();
    check("t4Free4", 64'(bus.OUT_freeCount), 4);
    check("t4NotFull", 64'(bus.OUT_full), 0);
    enq(0, 24, 100, 0, 101, 1);
    tick();
    check("t4Free3", 64'(bus.OUT_freeCount), 3);
    check("t4Full", 64'(bus.OUT_full), 1);
    enq(0, 25, 1, 1, 1, 1);
    tick();
    check("t4Ignored", 64'(bus.OUT_freeCount), 3);
    check("t4NoIssue", 64'(bus.OUT_issueValid), 0);
    wb(2, 100);
    for (int s = 20; s < 25; s++)
      expectIssue(s);
    tick();
    for (int n = 0; n < 5; n++)
      tick();
    check("t4Drained", 64'(bus.OUT_freeCount), 8);
    tick();
    check("t4Idle", 64'(bus.OUT_issueValid), 0);

    // 5a: flush younger entries while stalled
    bus.IN_issueStall = 1'b1;
    for (int l = 0; l < 4; l++)
      enq(l, 10 + l, 1, 1, 1, 1);
    tick();
    check("t5Free4", 64'(bus.OUT_freeCount), 4);
    flush(11);
    tick();
    check("t5Free6", 64'(bus.OUT_freeCount), 6);
    bus.IN_issueStall = 1'b0;
    expectIssue(10);
    expectIssue(11);
    tick();
    tick();
    check("t5Free8", 64'(bus.OUT_freeCount), 8);
    tick();
    check("t5Idle", 64'(bus.OUT_issueValid), 0);

    // 5b: held younger uop is cleared
    enq(0, 12, 1, 1, 1, 1);
    expectIssue(12);
    tick();
    tick();
    bus.IN_issueStall = 1'b1;
    tick();
    check("t5Hold", 64'(bus.OUT_issueValid), 1);
    check("t5HoldSqN", 64'(bus.OUT_issueSqN), 12);
    flush(11);
    tick();
    check("t5Cleared", 64'(bus.OUT_issueValid), 0);
    bus.IN_issueStall = 1'b0;

    // 5c: held older uop survives the flush
    enq(0, 10, 1, 1, 1, 1);
    expectIssue(10);
    tick();
    tick();
    bus.IN_issueStall = 1'b1;
    flush(11);
    tick();
    check("t5Keep", 64'(bus.OUT_issueValid), 1);
    check("t5KeepSqN", 64'(bus.OUT_issueSqN), 10);
    bus.IN_issueStall = 1'b0;
    tick();
    check("t5Drop", 64'(bus.OUT_issueValid), 0);

    // 6: enqueue-time bypass of a broadcast tag
    enq(0, 30, 5, 1, 20, 0);
    wb(1, 20);
    expectIssue(30);
    tick();
    check("t6Free7", 64'(bus.OUT_freeCount), 7);
    tick();
    check("t6Issue", 64'(bus.OUT_issueValid), 1);
    check("t6Free8", 64'(bus.OUT_freeCount), 8);

    // reset mid-operation
    enq(0, 40, 50, 0, 51, 1);
    enq(1, 41, 1, 1, 1, 1);
    tick();
    check("rstMidFree6", 64'(bus.OUT_freeCount), 6);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstMidFree", 64'(bus.OUT_freeCount), 8);
    check("rstMidValid", 64'(bus.OUT_issueValid), 0);
    tick();
    check("rstMidIdle", 64'(bus.OUT_issueValid), 0);
    check("rstMidEmpty", 64'(bus.OUT_freeCount), 8);

    check("sbDrained", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nVec, nErr);
    $finish;
  end

endmodule
